axi_write_slave: RTL
====================

// Module: axi_write_slave
// PURPOSE
//  AXI3-style write-channel slave: the downstream consumer of the write master's AW/W channels.
//  Accepts one burst at a time, writes beats into an internal byte-strobed word memory and returns one B response per burst.
//  Sits between the interconnect/master write ports and on-chip storage; the debug read port exists for testbench checking.
// PARAMETERS
//  DATA_W   32   WDATA width in bits (32 or 64); STRB_W = DATA_W/8
//  ID_W     4    AWID/WID/BID width
//  DEPTH    256  memory depth in DATA_W words; a power of 2
// PORTS
//  ACLK      in   1        sole clock; all logic on posedge
//  ARESETn   in   1        synchronous, active-low reset
//  AWID      in   ID_W     burst ID
//  AWADDR    in   32       byte start address
//  AWLEN     in   4        beats-1
//  AWSIZE    in   3        log2(bytes per beat)
//  AWBURST   in   2        00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  AWVALID   in   1        address valid
//  AWREADY   out  1        address ready
//  WID       in   ID_W     data ID
//  WDATA     in   DATA_W   write data
//  WSTRB     in   STRB_W   byte-lane enables
//  WLAST     in   1        final beat marker
//  WVALID    in   1        data valid
//  WREADY    out  1        data ready
//  BID       out  ID_W     response ID (= captured AWID)
//  BRESP     out  2        00 OKAY, 10 SLVERR
//  BVALID    out  1        response valid
//  BREADY    in   1        response ready
//  dbg_addr  in   log2(DEPTH)  debug word index
//  dbg_data  out  DATA_W   combinational read of mem[dbg_addr]
// BEHAVIOUR
//  - Reset: AWREADY=0, WREADY=0, BVALID=0, BID=0, BRESP=00, state=IDLE, beat counter=0; memory NOT cleared. Reset mid-burst abandons the burst, no B.
//  - Moore FSM; AWREADY/WREADY/BVALID decoded from registered state: IDLE->AWREADY=1; DATA->WREADY=1; RESP->BVALID=1.
//  - IDLE: on AWVALID&&AWREADY capture AWID/ADDR/LEN/SIZE/BURST, clear err flag and beat count, go DATA.
//  - DATA: each WVALID&&WREADY writes the WSTRB-enabled bytes of mem[addr>>log2(STRB_W) mod DEPTH] (unless err), then advances addr and count.
//    After beat count==AWLEN handshake, go RESP. Beats accepted = AWLEN+1 regardless of WLAST (see macro).
//  - RESP: hold BVALID/BID/BRESP stable until BREADY; on BVALID&&BREADY go IDLE. BRESP=10 if err flag set else 00.
//  - Latency: AW hs in cycle N -> WREADY high N+1; last W hs in cycle M -> BVALID high M+1; B hs in cycle K -> AWREADY high K+1.
//  - Address step: FIXED none; INCR +(1<<AWSIZE), 32-bit wrap; WRAP aligns to (AWLEN+1)<<AWSIZE boundary and wraps within it.
//  - err set at AW capture (data still consumed, no mem writes): AWBURST=11; AWSIZE>log2(STRB_W); WRAP with AWLEN not in {1,3,7,15};
//    WRAP with unaligned AWADDR; start word index >=DEPTH. INCR crossing DEPTH mid-burst sets err and suppresses remaining writes.
//  - WSTRB=0 beat: counted, no bytes written. WVALID while not in DATA: ignored, WREADY stays 0.
// CONFIGURATION
//  AXI_WR_SLV_PROTOCOL_CHECK_EN defined: a beat with WID != captured AWID, WLAST=1 before beat AWLEN, or WLAST=0 on beat AWLEN sets err (SLVERR);
//    burst length still AWLEN+1, offending and later beats not written.
//  Undefined: WID and WLAST ignored; response depends only on AW-phase/range checks.
// STRUCTURE
//  Package axi_wr_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/SLVERR localparams, FSM state encodings (IDLE/DATA/RESP, 2 bits).
//  Sub-module axi_burst_addr_gen: combinational next-address from (addr, size, len, burst); reusable by a future read slave.
// TESTING
//  1 INCR: AWADDR=0x10,LEN=3,SIZE=2,data A0..A3,WSTRB=F -> mem[4..7]=A0..A3, BRESP=00, BID=AWID, BVALID 1 cycle after last beat.
//  2 WRAP: AWADDR=0x38,LEN=3,SIZE=2 -> words 14,15,12,13 written in order; BRESP=00.
//  3 FIXED: AWADDR=0x20,LEN=2,WSTRB 1,2,4 with data 11,2200,330000 -> mem[8]=0x00332211; BRESP=00.
//  4 Errors: AWBURST=11 LEN=1 -> 2 beats accepted, mem unchanged, BRESP=10; AWADDR=DEPTH*4 -> BRESP=10, no writes.
//  5 Backpressure: hold BREADY=0 10 cycles -> BVALID/BID/BRESP stable, AWREADY=0 throughout; random WVALID gaps -> identical mem.
//  6 Reset mid DATA after beat 1 of LEN=3 -> all outputs at reset values next cycle; new burst after reset completes OKAY.
//    With AXI_WR_SLV_PROTOCOL_CHECK_EN: early WLAST on beat 1 of LEN=3 -> BRESP=10, only beat 0 written.

Source files
------------

// File: rtl/axi_wr_pkg.sv
// Shared encodings for the AXI write slave: burst types, response codes and FSM states.
// Also holds small helpers that a future read slave can reuse.
package axi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wrapping bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic is_wrap_len(input logic [3:0] len);
    is_wrap_len = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat byte address for FIXED/INCR/WRAP bursts.
// Shared between write and (future) read slaves.
module axi_burst_addr_gen
  import axi_wr_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [3:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step;
  logic [31:0] wrap_mask;

  assign step      = 32'd1 << size;
  assign wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;

  // WRAP keeps the upper bits of the container and only rolls the offset inside it.
  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = addr + step;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | ((addr + step) & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_write_slave.sv
// AXI3-style write slave: one burst at a time into a byte-strobed word memory, one B per burst.
// Define AXI_WR_SLV_PROTOCOL_CHECK_EN to flag WID/WLAST protocol violations as SLVERR.
module axi_write_slave
  import axi_wr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int DEPTH  = 256
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [ID_W-1:0]          AWID,
  input  logic [31:0]              AWADDR,
  input  logic [3:0]               AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [ID_W-1:0]          WID,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [DATA_W/8-1:0]      WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [ID_W-1:0]          BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = $clog2(DEPTH);

  state_t            state;
  logic [31:0]       cur_addr;
  logic [3:0]        cur_len;
  logic [2:0]        cur_size;
  logic [1:0]        cur_burst;
  logic [ID_W-1:0]   cur_id;
  logic [3:0]        beat_cnt;
  logic              err;

  logic [31:0]       next_addr;
  logic [31:0]       word_idx;
  logic              in_range;
  logic              w_hs;
  logic              proto_err;
  logic              beat_err;
  logic              wr_en;
  logic              aw_err;

  logic [DATA_W-1:0] mem [DEPTH];

  axi_burst_addr_gen u_addr_gen (
    .addr      (cur_addr),
    .size      (cur_size),
    .len       (cur_len),
    .burst     (cur_burst),
    .next_addr (next_addr)
  );

  // Burst legality is decided once at address capture; data is still drained on error.
  always_comb begin
    aw_err = 1'b0;
    if (AWBURST == BURST_RSVD)
      aw_err = 1'b1;
    if (AWSIZE > 3'(ADDR_LSB))
      aw_err = 1'b1;
    if (AWBURST == BURST_WRAP && !is_wrap_len(AWLEN))
      aw_err = 1'b1;
    if (AWBURST == BURST_WRAP && ((AWADDR & ((32'd1 << AWSIZE) - 32'd1)) != 32'd0))
      aw_err = 1'b1;
    if ((AWADDR >> ADDR_LSB) >= 32'(DEPTH))
      aw_err = 1'b1;
  end

  assign word_idx = cur_addr >> ADDR_LSB;
  assign in_range = word_idx < 32'(DEPTH);
  assign w_hs     = WVALID && WREADY;

`ifdef AXI_WR_SLV_PROTOCOL_CHECK_EN
  assign proto_err = (WID != cur_id) ||
                     (WLAST && (beat_cnt != cur_len)) ||
                     (!WLAST && (beat_cnt == cur_len));
`else
  logic unused_proto;
  assign unused_proto = ^{WID, WLAST};
  assign proto_err    = 1'b0;
`endif

  assign beat_err = !in_range || proto_err;
  assign wr_en    = w_hs && ARESETn && !err && !beat_err;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state     <= IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BID       <= '0;
      BRESP     <= RESP_OKAY;
      beat_cnt  <= 4'd0;
      err       <= 1'b0;
      cur_addr  <= 32'd0;
      cur_len   <= 4'd0;
      cur_size  <= 3'd0;
      cur_burst <= BURST_FIXED;
      cur_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          AWREADY <= 1'b1;
          if (AWVALID && AWREADY) begin
            cur_id    <= AWID;
            cur_addr  <= AWADDR;
            cur_len   <= AWLEN;
            cur_size  <= AWSIZE;
            cur_burst <= AWBURST;
            err       <= aw_err;
            beat_cnt  <= 4'd0;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            cur_addr <= next_addr;
            beat_cnt <= beat_cnt + 4'd1;
            err      <= err || beat_err;
            if (beat_cnt == cur_len) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BID    <= cur_id;
              BRESP  <= (err || beat_err) ? RESP_SLVERR : RESP_OKAY;
              state  <= RESP;
            end
          end
        end
        RESP: begin
          if (BVALID && BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          AWREADY <= 1'b0;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Storage is deliberately left out of reset so contents survive an abandoned burst.
  always_ff @(posedge ACLK) begin
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b])
          mem[word_idx[IDX_W-1:0]][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule
